// File: rtl/cursor_ctrl.sv
// Tic-tac-toe board cursor: tracks the selected cell from button pulses, runs the
// blink/reject/lock sequencing, and issues move requests to the game logic.
module cursor_ctrl #(
  parameter int H0            = 0,
  parameter int V0            = 0,
  parameter int CELL_W        = 213,
  parameter int CELL_H        = 160,
  parameter int BLINK_FRAMES  = 15,
  parameter int REJECT_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  input  logic [8:0]  cell_occupied,
  input  logic        lock,
  input  logic        place_ack,
  output logic        place_req,
  output logic [3:0]  place_idx,
  output logic [3:0]  cur_idx,
  output logic [10:0] hmin,
  output logic [10:0] vmin,
  output logic        cur_en
);

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_PLACE, S_REJECT, S_LOCK} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cur_idx_q, cur_idx_d;
  logic [3:0]         place_idx_q, place_idx_d;
  logic               place_req_q, place_req_d;
  logic               phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [10:0]        hmin_q, vmin_q;
  logic               cur_en_q;

  logic [1:0]         row, col;
  logic [10:0]        tgt_x, tgt_y;
  logic               en_int;
  logic [3:0]         mv_idx;
  logic               any_move;

  always_comb begin
    row = 2'd0;
    if (cur_idx_q >= 4'd6)      row = 2'd2;
    else if (cur_idx_q >= 4'd3) row = 2'd1;
    col   = 2'(cur_idx_q - 4'(row) * 4'd3);
    tgt_x = 11'(H0 + int'(col) * CELL_W);
    tgt_y = 11'(V0 + int'(row) * CELL_H);
  end

  // Moves wrap inside the current row/column; priority up > down > left > right.
  always_comb begin
    mv_idx   = cur_idx_q;
    any_move = btn_up | btn_down | btn_left | btn_right;
    if (btn_up)         mv_idx = (row == 2'd0) ? cur_idx_q + 4'd6 : cur_idx_q - 4'd3;
    else if (btn_down)  mv_idx = (row == 2'd2) ? cur_idx_q - 4'd6 : cur_idx_q + 4'd3;
    else if (btn_left)  mv_idx = (col == 2'd0) ? cur_idx_q + 4'd2 : cur_idx_q - 4'd1;
    else if (btn_right) mv_idx = (col == 2'd2) ? cur_idx_q - 4'd2 : cur_idx_q + 4'd1;
  end

  always_comb begin
    en_int = 1'b0;
    case (state_q)
      S_IDLE:   en_int = phase_q;
      S_PLACE:  en_int = 1'b1;
      S_REJECT: en_int = phase_q;
      default:  en_int = 1'b0;
    endcase
  end

  // Request handshake: place_req rises with place_idx valid and both hold until
  // place_ack is sampled high; place_req drops on the following edge.
  always_comb begin
    state_d     = state_q;
    cur_idx_d   = cur_idx_q;
    place_idx_d = place_idx_q;
    place_req_d = place_req_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (lock) begin
          state_d = S_LOCK;
        end else if (btn_sel) begin
          if (cell_occupied[cur_idx_q]) begin
            state_d = S_REJECT;
            cnt_d   = '0;
          end else begin
            state_d     = S_PLACE;
            place_idx_d = cur_idx_q;
            place_req_d = 1'b1;
          end
        end else if (any_move) begin
          cur_idx_d = mv_idx;
          phase_d   = 1'b1;
          cnt_d     = '0;
        end else if (frame_tick) begin
          if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_PLACE: begin
        if (place_ack && place_req_q) begin
          place_req_d = 1'b0;
          if (lock) begin
            state_d = S_LOCK;
          end else begin
            state_d = S_IDLE;
            phase_d = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      S_REJECT: begin
        if (lock) begin
          state_d = S_LOCK;
        end else if (frame_tick) begin
          if (cnt_q == CNT_W'(REJECT_FRAMES - 1)) begin
            state_d = S_IDLE;
            phase_d = 1'b1;
            cnt_d   = '0;
          end else begin
            phase_d = ~phase_q;
            cnt_d   = cnt_q + 8'd1;
          end
        end
      end
      default: begin
        if (!lock) begin
          state_d = S_IDLE;
          phase_d = 1'b1;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_idx_q   <= 4'd4;
      place_idx_q <= 4'd0;
      place_req_q <= 1'b0;
      phase_q     <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_idx_q   <= cur_idx_d;
      place_idx_q <= place_idx_d;
      place_req_q <= place_req_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
    end
  end

  // Display registers sample the pre-update targets, so a move on a tick shows next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hmin_q   <= 11'(H0 + CELL_W);
      vmin_q   <= 11'(V0 + CELL_H);
      cur_en_q <= 1'b0;
    end else if (frame_tick) begin
      hmin_q   <= tgt_x;
      vmin_q   <= tgt_y;
      cur_en_q <= en_int;
    end
  end

  assign place_req = place_req_q;
  assign place_idx = place_idx_q;
  assign cur_idx   = cur_idx_q;
  assign hmin      = hmin_q;
  assign vmin      = vmin_q;
  assign cur_en    = cur_en_q;

endmodule
